// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache
// miss handlers; sequences whole-block bursts and routes the word handshake to the owner.
module mem_bus_arbiter #(
  parameter int BLOCKSIZE = 4,
  parameter int WIDX      = $clog2(BLOCKSIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IReq,
  input  logic [31:0]     IAdr,
  input  logic            DReq,
  input  logic            DWE,
  input  logic [31:0]     DAdr,
  input  logic [31:0]     DWD,
  output logic            IRdy,
  output logic            DRdy,
  output logic            IDone,
  output logic            DDone,
  output logic [WIDX-1:0] WordIdx,
  output logic [31:0]     RD,
  output logic            Busy,
  output logic            MemReq,
  output logic            MemWE,
  output logic [31:0]     MemAdr,
  output logic [31:0]     MemWD,
  input  logic [31:0]     MemRD,
  input  logic            MemAck
);

  typedef enum logic [1:0] {IDLE, IBURST, DBURST} state_t;

  state_t          state, nextState;
  logic [WIDX-1:0] cnt;
  logic [31:0]     base;
  logic            wr;
  logic            lastD;     // owner of the most recently completed burst: 1 = D, 0 = I
  logic            maskFlag;  // high only in the IDLE cycle right after a burst completes
  logic            iElig, dElig, grantI, grantD, lastWord;

  assign lastWord = (cnt == WIDX'(BLOCKSIZE - 1));
  assign iElig    = IReq & ~(maskFlag & ~lastD);
  assign dElig    = DReq & ~(maskFlag & lastD);

  assign RD    = MemRD;
  assign MemWD = DWD;
  assign Busy  = (state != IDLE);

  always_comb begin
    nextState = state;
    grantI    = 1'b0;
    grantD    = 1'b0;
    MemReq    = 1'b0;
    MemWE     = 1'b0;
    MemAdr    = '0;
    WordIdx   = '0;
    IRdy      = 1'b0;
    DRdy      = 1'b0;
    IDone     = 1'b0;
    DDone     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (iElig && dElig) begin
          grantI = lastD;
          grantD = ~lastD;
        end else begin
          grantI = iElig;
          grantD = dElig;
        end
        if (grantI)      nextState = IBURST;
        else if (grantD) nextState = DBURST;
      end
      IBURST: begin
        MemReq  = 1'b1;
        MemAdr  = {base[31:WIDX+2], cnt, 2'b00};
        WordIdx = cnt;
        IRdy    = MemAck;
        IDone   = MemAck & lastWord;
        if (MemAck && lastWord) nextState = IDLE;
      end
      DBURST: begin
        MemReq  = 1'b1;
        MemWE   = wr;
        MemAdr  = {base[31:WIDX+2], cnt, 2'b00};
        WordIdx = cnt;
        DRdy    = MemAck;
        DDone   = MemAck & lastWord;
        if (MemAck && lastWord) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      base     <= '0;
      wr       <= 1'b0;
      lastD    <= 1'b0;
      maskFlag <= 1'b0;
    end else begin
      state    <= nextState;
      maskFlag <= 1'b0;
      if (grantI || grantD) begin
        base <= grantI ? IAdr : DAdr;
        cnt  <= '0;
      end
      if (grantD) wr <= DWE;
      if ((state != IDLE) && MemAck) begin
        cnt <= cnt + 1'b1;
        if (lastWord) begin
          lastD    <= (state == DBURST);
          maskFlag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with BLOCKSIZE = 4.
module tb_mem_bus_arbiter;

  localparam int BLOCKSIZE = 4;
  localparam int WIDX      = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            IReq, DReq, DWE, MemAck;
  logic [31:0]     IAdr, DAdr, DWD, MemRD;
  logic            IRdy, DRdy, IDone, DDone, Busy, MemReq, MemWE;
  logic [WIDX-1:0] WordIdx;
  logic [31:0]     RD, MemAdr, MemWD;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.BLOCKSIZE(BLOCKSIZE), .WIDX(WIDX)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAdr(IAdr), .DReq(DReq), .DWE(DWE), .DAdr(DAdr), .DWD(DWD),
    .IRdy(IRdy), .DRdy(DRdy), .IDone(IDone), .DDone(DDone), .WordIdx(WordIdx),
    .RD(RD), .Busy(Busy), .MemReq(MemReq), .MemWE(MemWE), .MemAdr(MemAdr),
    .MemWD(MemWD), .MemRD(MemRD), .MemAck(MemAck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; IReq = 1'b0; DReq = 1'b0; DWE = 1'b0; MemAck = 1'b0;
    IAdr = '0; DAdr = '0; DWD = '0; MemRD = 32'h0;

    // Reset values
    tick(); tick(); #1;
    chk("rst_memreq", 32'(MemReq), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_wordidx", 32'(WordIdx), 32'h0);
    chk("rst_rdydone", 32'({IRdy, DRdy, IDone, DDone}), 32'h0);
    reset = 1'b1;
    tick(); tick();
    chk("idle_after_rst", 32'({Busy, MemReq, MemWE}), 32'h0);

    // Single I fill, zero wait
    IReq = 1'b1; IAdr = 32'h0000_1234; MemAck = 1'b1; #1;
    chk("i_pre_grant_busy", 32'(Busy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); MemRD = 32'hC0DE_0000 + k; #1;
      chk("i_adr", MemAdr, 32'(32'h1230 + 4 * k));
      chk("i_rdy", 32'(IRdy), 32'h1);
      chk("i_done", 32'(IDone), 32'((k == 3) ? 1 : 0));
      chk("i_we", 32'(MemWE), 32'h0);
      chk("i_drdy", 32'(DRdy), 32'h0);
      chk("i_rd", RD, 32'(32'hC0DE_0000 + k));
      chk("i_wordidx", 32'(WordIdx), 32'(k));
      if (k == 3) IReq = 1'b0;
    end
    tick();
    chk("i_busy_fall", 32'({Busy, MemReq}), 32'h0);

    // Tie after reset: D first, I granted in the masked IDLE cycle
    reset = 1'b0; #2; reset = 1'b1;
    IReq = 1'b1; DReq = 1'b1; DWE = 1'b0; IAdr = 32'h0000_3000; DAdr = 32'h0000_2000; #1;
    chk("tie_pre_busy", 32'(Busy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_d_rdy", 32'({DRdy, IRdy}), 32'h2);
      chk("tie_d_adr", MemAdr, 32'(32'h2000 + 4 * k));
      chk("tie_d_done", 32'(DDone), 32'((k == 3) ? 1 : 0));
      if (k == 3) DReq = 1'b0;
    end
    tick();
    chk("tie_idle_gap", 32'({Busy, MemReq}), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_i_req", 32'({MemReq, IRdy}), 32'h3);
      chk("tie_i_adr", MemAdr, 32'(32'h3000 + 4 * k));
      if (k == 3) IReq = 1'b0;
    end
    tick();
    chk("tie_end_idle", 32'(Busy), 32'h0);

    // D write-back with an ack every 3rd cycle
    tick();
    DReq = 1'b1; DWE = 1'b1; DAdr = 32'h8000_0040; MemAck = 1'b0; #1;
    chk("wb_pre_busy", 32'(Busy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        tick();
        MemAck = (w == 2);
        DWD = 32'h1111_0000 + 32'(k * 16 + w);
        #1;
        chk("wb_we", 32'(MemWE), 32'h1);
        chk("wb_wordidx", 32'(WordIdx), 32'(k));
        chk("wb_adr", MemAdr, 32'(32'h8000_0040 + 4 * k));
        chk("wb_wd", MemWD, 32'(32'h1111_0000 + k * 16 + w));
        chk("wb_drdy", 32'(DRdy), 32'((w == 2) ? 1 : 0));
        chk("wb_ddone", 32'(DDone), 32'((w == 2 && k == 3) ? 1 : 0));
        if (k == 3 && w == 2) DReq = 1'b0;
      end
    end
    tick(); MemAck = 1'b0; #1;
    chk("wb_end_idle", 32'({Busy, MemWE}), 32'h0);

    // Round-robin and masking
    IReq = 1'b1; DReq = 1'b1; DWE = 1'b0; IAdr = 32'h0000_6000; DAdr = 32'h0000_7000;
    MemAck = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_i_first", 32'({IRdy, DRdy}), 32'h2);
      chk("rr_i_adr", MemAdr, 32'(32'h6000 + 4 * k));
    end
    tick();
    chk("rr_gap1", 32'(Busy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_d_next", 32'({IRdy, DRdy}), 32'h1);
      chk("rr_d_adr", MemAdr, 32'(32'h7000 + 4 * k));
      if (k == 0) DReq = 1'b0;
    end
    tick();
    chk("rr_gap2", 32'(Busy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_i_again", 32'(IRdy), 32'h1);
      chk("rr_i_done", 32'(IDone), 32'((k == 3) ? 1 : 0));
    end
    tick();
    chk("mask_cycle", 32'(Busy), 32'h0);
    tick();
    chk("mask_grant_cycle", 32'(Busy), 32'h0);
    tick();
    chk("mask_regrant", 32'({Busy, MemReq, IRdy}), 32'h7);
    chk("mask_regrant_idx", 32'(WordIdx), 32'h0);
    IReq = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("mask_burst_idx", 32'(WordIdx), 32'(k));
    end
    tick();
    chk("mask_end_idle", 32'(Busy), 32'h0);

    // Reset mid-burst
    DReq = 1'b1; DWE = 1'b0; DAdr = 32'h0000_4000; #1;
    tick(); tick(); tick();
    chk("mid_idx_before", 32'(WordIdx), 32'h2);
    reset = 1'b0; DReq = 1'b0; MemRD = 32'h0000_BEEF; #1;
    chk("mid_memreq", 32'(MemReq), 32'h0);
    chk("mid_busy", 32'(Busy), 32'h0);
    chk("mid_idx", 32'(WordIdx), 32'h0);
    chk("mid_adr", MemAdr, 32'h0);
    chk("mid_drdy", 32'({DRdy, DDone}), 32'h0);
    chk("mid_rd", RD, 32'h0000_BEEF);
    reset = 1'b1; IReq = 1'b1; IAdr = 32'h0000_5008;
    tick();
    chk("post_busy", 32'({Busy, IRdy}), 32'h3);
    chk("post_idx", 32'(WordIdx), 32'h0);
    chk("post_adr", MemAdr, 32'h0000_5000);
    IReq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
